// File: rtl/param_instruction_queue_pkg.sv
// Shared field widths and the decoded-instruction record carried through the queue.
// Address is held at its maximum width; the queue narrows it to ADDR_W at the ports.
package iq_pkg;
  localparam int OPC_W      = 4;
  localparam int REG_W      = 5;
  localparam int SCALE_W    = 2;
  localparam int ADDR_MAX_W = 64;

  typedef struct packed {
    logic [OPC_W-1:0]      MajorOpcode;
    logic [REG_W-1:0]      Source1;
    logic [REG_W-1:0]      Source2;
    logic [SCALE_W-1:0]    OffsetScale;
    logic [REG_W-1:0]      Destination;
    logic [OPC_W-1:0]      MinorOpcode;
    logic                  HasAddress;
    logic [ADDR_MAX_W-1:0] Address;
    logic                  OffsetSub;
  } instr_t;

  localparam instr_t INSTR_ZERO = '0;
endpackage

// File: rtl/param_instruction_queue_if.sv
// Decode-side and issue-side signals of the instruction queue; slave is the queue, master drives it.
// Latency 1 cycle (0 with bypass); upstream holds while stall_out, head holds while stall_in.
interface param_instruction_queue_if import iq_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 48
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               valid_in;
  logic [OPC_W-1:0]   MajorOpcode_in;
  logic [REG_W-1:0]   Source1_in;
  logic [REG_W-1:0]   Source2_in;
  logic [SCALE_W-1:0] OffsetScale_in;
  logic [REG_W-1:0]   Destination_in;
  logic [OPC_W-1:0]   MinorOpcode_in;
  logic               HasAddress_in;
  logic [ADDR_W-1:0]  Address_in;
  logic               OffsetSub_in;
  logic               stall_in;
  logic               flush;

  logic               stall_out;
  logic               valid_out;
  logic [OPC_W-1:0]   MajorOpcode_out;
  logic [REG_W-1:0]   Source1_out;
  logic [REG_W-1:0]   Source2_out;
  logic [SCALE_W-1:0] OffsetScale_out;
  logic [REG_W-1:0]   Destination_out;
  logic [OPC_W-1:0]   MinorOpcode_out;
  logic               HasAddress_out;
  logic [ADDR_W-1:0]  Address_out;
  logic               OffsetSub_out;
  logic [CNT_W-1:0]   count;
  logic               almost_full;

  modport slave (
    input  valid_in, MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in,
           Destination_in, MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in,
           stall_in, flush,
    output stall_out, valid_out, MajorOpcode_out, Source1_out, Source2_out,
           OffsetScale_out, Destination_out, MinorOpcode_out, HasAddress_out,
           Address_out, OffsetSub_out, count, almost_full
  );

  modport master (
    output valid_in, MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in,
           Destination_in, MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in,
           stall_in, flush,
    input  stall_out, valid_out, MajorOpcode_out, Source1_out, Source2_out,
           OffsetScale_out, Destination_out, MinorOpcode_out, HasAddress_out,
           Address_out, OffsetSub_out, count, almost_full
  );
endinterface

// File: rtl/param_instruction_queue_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty/almost-full decode for the queue.
// Callers must only assert push when not full and pop when not empty; flush wins over both.
module iq_ptr_ctrl #(
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH)-1:0]     wr_ptr,
  output logic [$clog2(DEPTH)-1:0]     rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so plain increment wraps correctly.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AFULL_THRESH));
endmodule

// File: rtl/param_instruction_queue.sv
// In-order decode-to-issue instruction queue, 1-cycle enqueue latency; stall_out when full.
// Define IQ_BYPASS_EN to present an arriving instruction combinationally when the queue is empty.
module param_instruction_queue import iq_pkg::*; #(
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 48,
  parameter int AFULL_THRESH = DEPTH - 2
) (
  input  logic                    clk,
  input  logic                    reset,
  param_instruction_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             push;
  logic             pop;
  instr_t           in_rec;
  instr_t           head_rec;
  instr_t           mem [DEPTH];

  assign in_rec = '{
    MajorOpcode: q.MajorOpcode_in,
    Source1:     q.Source1_in,
    Source2:     q.Source2_in,
    OffsetScale: q.OffsetScale_in,
    Destination: q.Destination_in,
    MinorOpcode: q.MinorOpcode_in,
    HasAddress:  q.HasAddress_in,
    Address:     ADDR_MAX_W'(q.Address_in),
    OffsetSub:   q.OffsetSub_in
  };

`ifdef IQ_BYPASS_EN
  logic bypass;
  logic bypass_take;

  // An arrival into an empty queue is shown at the head straight away; it
  // only lands in storage if issue stalls it.
  assign bypass      = empty && q.valid_in && !q.flush;
  assign bypass_take = bypass && !q.stall_in;
  assign push        = q.valid_in && !full && !bypass_take;
  assign head_rec    = bypass ? in_rec : (empty ? INSTR_ZERO : mem[rd_ptr]);
  assign q.valid_out = !empty || bypass;
`else
  assign push        = q.valid_in && !full;
  assign head_rec    = empty ? INSTR_ZERO : mem[rd_ptr];
  assign q.valid_out = !empty;
`endif

  assign pop = !empty && !q.stall_in;

  always_ff @(posedge clk) begin
    if (push && !q.flush) mem[wr_ptr] <= in_rec;
  end

  iq_ptr_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_ptr_ctrl (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .flush       (q.flush),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full)
  );

  assign q.stall_out       = full;
  assign q.count           = count;
  assign q.almost_full     = almost_full;
  assign q.MajorOpcode_out = head_rec.MajorOpcode;
  assign q.Source1_out     = head_rec.Source1;
  assign q.Source2_out     = head_rec.Source2;
  assign q.OffsetScale_out = head_rec.OffsetScale;
  assign q.Destination_out = head_rec.Destination;
  assign q.MinorOpcode_out = head_rec.MinorOpcode;
  assign q.HasAddress_out  = head_rec.HasAddress;
  assign q.Address_out     = ADDR_W'(head_rec.Address);
  assign q.OffsetSub_out   = head_rec.OffsetSub;
endmodule

// File: tb/tb_param_instruction_queue.sv
// Scoreboarded bench for param_instruction_queue (48-bit and 32-bit address instances).
module tb_param_instruction_queue;
  import iq_pkg::*;

  localparam int DEPTH = 8;
`ifdef IQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  param_instruction_queue_if #(.DEPTH(DEPTH), .ADDR_W(48)) qi ();
  param_instruction_queue_if #(.DEPTH(DEPTH), .ADDR_W(32)) qi32 ();

  param_instruction_queue #(.DEPTH(DEPTH), .ADDR_W(48), .AFULL_THRESH(DEPTH-2)) dut (
    .clk(clk), .reset(reset), .q(qi));
  param_instruction_queue #(.DEPTH(DEPTH), .ADDR_W(32), .AFULL_THRESH(DEPTH-2)) dut32 (
    .clk(clk), .reset(reset), .q(qi32));

  int     tests_run = 0;
  int     fails = 0;
  bit     mon_en = 1'b0;
  instr_t exp_q[$];
  instr_t in_rec;
  instr_t out_rec;

  assign in_rec = '{qi.MajorOpcode_in, qi.Source1_in, qi.Source2_in, qi.OffsetScale_in,
                    qi.Destination_in, qi.MinorOpcode_in, qi.HasAddress_in,
                    64'(qi.Address_in), qi.OffsetSub_in};
  assign out_rec = '{qi.MajorOpcode_out, qi.Source1_out, qi.Source2_out, qi.OffsetScale_out,
                     qi.Destination_out, qi.MinorOpcode_out, qi.HasAddress_out,
                     64'(qi.Address_out), qi.OffsetSub_out};

  function automatic instr_t rand_rec();
    instr_t r;
    r = '0;
    r.MajorOpcode = 4'($urandom);
    r.Source1     = 5'($urandom);
    r.Source2     = 5'($urandom);
    r.OffsetScale = 2'($urandom);
    r.Destination = 5'($urandom);
    r.MinorOpcode = 4'($urandom);
    r.HasAddress  = 1'($urandom);
    r.Address     = {16'h0, 16'($urandom), 32'($urandom)};
    r.OffsetSub   = 1'($urandom);
    return r;
  endfunction

  task automatic set_in(input bit v, input instr_t r, input bit st, input bit fl);
    qi.valid_in       = v;
    qi.MajorOpcode_in = r.MajorOpcode;
    qi.Source1_in     = r.Source1;
    qi.Source2_in     = r.Source2;
    qi.OffsetScale_in = r.OffsetScale;
    qi.Destination_in = r.Destination;
    qi.MinorOpcode_in = r.MinorOpcode;
    qi.HasAddress_in  = r.HasAddress;
    qi.Address_in     = r.Address[47:0];
    qi.OffsetSub_in   = r.OffsetSub;
    qi.stall_in       = st;
    qi.flush          = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compares the head against the model at each negedge, then
  // applies the push/pop/flush that the coming edge will perform.
  always @(negedge clk) begin
    int     n;
    bit     byp;
    bit     ev;
    instr_t eh;
    if (mon_en) begin
      n = exp_q.size();
      byp = BYP && (n == 0) && qi.valid_in && !qi.flush;
      ev = (n != 0) || byp;
      eh = (n != 0) ? exp_q[0] : (byp ? in_rec : instr_t'('0));
      tests_run++;
      if (qi.valid_out !== ev) begin
        fails++; $display("FAIL mon_valid_out: got %b expected %b", qi.valid_out, ev);
      end
      tests_run++;
      if (qi.count !== 4'(n)) begin
        fails++; $display("FAIL mon_count: got %0d expected %0d", qi.count, n);
      end
      tests_run++;
      if (qi.stall_out !== (n == DEPTH)) begin
        fails++; $display("FAIL mon_stall_out: got %b expected %b", qi.stall_out, n == DEPTH);
      end
      tests_run++;
      if (qi.almost_full !== (n >= DEPTH - 2)) begin
        fails++; $display("FAIL mon_almost_full: got %b expected %b", qi.almost_full, n >= DEPTH-2);
      end
      tests_run++;
      if (out_rec !== eh) begin
        fails++; $display("FAIL mon_head: got %h expected %h", out_rec, eh);
      end
      if (qi.flush) begin
        exp_q.delete();
      end else if (!(byp && !qi.stall_in)) begin
        if (ev && !qi.stall_in) void'(exp_q.pop_front());
        if (qi.valid_in && n < DEPTH) exp_q.push_back(in_rec);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (qi.valid_out !== 1'b0 || qi.count !== 4'd0 || qi.stall_out !== 1'b0) begin
      fails++; $display("FAIL reset_ctl: valid %b count %0d stall %b expected 0 0 0",
                        qi.valid_out, qi.count, qi.stall_out);
    end
    tests_run++;
    if (qi.almost_full !== 1'b0) begin
      fails++; $display("FAIL reset_afull: got %b expected 0", qi.almost_full);
    end
    tests_run++;
    if (out_rec !== instr_t'('0)) begin
      fails++; $display("FAIL reset_rec: got %h expected 0", out_rec);
    end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset_midstream();
    instr_t r;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, rand_rec(), 1'b1, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    #2;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (qi.count !== 4'd0 || qi.valid_out !== 1'b0) begin
      fails++; $display("FAIL midreset_async: count %0d valid %b expected 0 0", qi.count, qi.valid_out);
    end
    tests_run++;
    if (out_rec !== instr_t'('0)) begin
      fails++; $display("FAIL midreset_rec: got %h expected 0", out_rec);
    end
    exp_q.delete();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    r = rand_rec();
    set_in(1'b1, r, 1'b1, 1'b0);
    #1;
    tests_run++;
    if (qi.valid_out !== BYP) begin
      fails++; $display("FAIL post_reset_latency0: valid %b expected %b", qi.valid_out, BYP);
    end
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (qi.valid_out !== 1'b1 || out_rec !== r || qi.count !== 4'd1) begin
      fails++; $display("FAIL post_reset_latency1: valid %b rec %h count %0d expected 1 %h 1",
                        qi.valid_out, out_rec, qi.count, r);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, rand_rec(), 1'b1, 1'b0);
      tick();
      tests_run++;
      if (qi.count !== 4'(i + 1) || qi.almost_full !== (i + 1 >= 6)) begin
        fails++; $display("FAIL fill_%0d: count %0d afull %b expected %0d %b",
                          i, qi.count, qi.almost_full, i + 1, i + 1 >= 6);
      end
    end
    set_in(1'b1, rand_rec(), 1'b1, 1'b0);
    tick();
    tests_run++;
    if (qi.count !== 4'd8 || qi.stall_out !== 1'b1 || qi.almost_full !== 1'b1) begin
      fails++; $display("FAIL fill_ninth: count %0d stall %b afull %b expected 8 1 1",
                        qi.count, qi.stall_out, qi.almost_full);
    end
  endtask

  task automatic test_full_pop();
    set_in(1'b1, rand_rec(), 1'b0, 1'b0);
    tick();
    tests_run++;
    if (qi.count !== 4'd7 || qi.stall_out !== 1'b0) begin
      fails++; $display("FAIL full_pop: count %0d stall %b expected 7 0", qi.count, qi.stall_out);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (7) tick();
    tests_run++;
    if (qi.valid_out !== 1'b0) begin
      fails++; $display("FAIL full_drain: valid %b expected 0", qi.valid_out);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, rand_rec(), 1'b0, 1'b0);
      tick();
      tests_run++;
      if (qi.count !== (BYP ? 4'd0 : 4'd1)) begin
        fails++; $display("FAIL stream_count_%0d: got %0d expected %0d", i, qi.count, BYP ? 0 : 1);
      end
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, rand_rec(), 1'b1, 1'b0);
      tick();
    end
    set_in(1'b1, rand_rec(), 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    tests_run++;
    if (qi.count !== 4'd0 || qi.valid_out !== 1'b0) begin
      fails++; $display("FAIL flush: count %0d valid %b expected 0 0", qi.count, qi.valid_out);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    tests_run++;
    if (qi.valid_out !== 1'b0) begin
      fails++; $display("FAIL flush_leak: valid %b expected 0", qi.valid_out);
    end
  endtask

  task automatic test_wide_addr();
    instr_t w;
    w = '0;
    w.MajorOpcode = 4'hA;
    w.HasAddress  = 1'b1;
    w.Address     = 64'h0000_FFFF_FFFF_FFFF;
    w.OffsetSub   = 1'b1;
    set_in(1'b1, w, 1'b1, 1'b0);
    qi32.valid_in       = 1'b1;
    qi32.MajorOpcode_in = 4'hA;
    qi32.HasAddress_in  = 1'b1;
    qi32.Address_in     = 32'hFFFF_FFFF;
    qi32.OffsetSub_in   = 1'b1;
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    qi32.valid_in = 1'b0;
    tests_run++;
    if (qi.Address_out !== 48'hFFFF_FFFF_FFFF || qi.OffsetSub_out !== 1'b1 ||
        qi.HasAddress_out !== 1'b1 || qi.MajorOpcode_out !== 4'hA) begin
      fails++; $display("FAIL wide_addr48: addr %h sub %b has %b op %h expected ffffffffffff 1 1 a",
                        qi.Address_out, qi.OffsetSub_out, qi.HasAddress_out, qi.MajorOpcode_out);
    end
    tests_run++;
    if (qi32.valid_out !== 1'b1 || qi32.Address_out !== 32'hFFFF_FFFF ||
        qi32.OffsetSub_out !== 1'b1 || qi32.HasAddress_out !== 1'b1) begin
      fails++; $display("FAIL wide_addr32: valid %b addr %h sub %b has %b expected 1 ffffffff 1 1",
                        qi32.valid_out, qi32.Address_out, qi32.OffsetSub_out, qi32.HasAddress_out);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    qi32.stall_in = 1'b0;
    tick();
    tests_run++;
    if (qi32.valid_out !== 1'b0 || qi32.Address_out !== 32'h0) begin
      fails++; $display("FAIL wide_addr32_drain: valid %b addr %h expected 0 0",
                        qi32.valid_out, qi32.Address_out);
    end
  endtask

  initial begin
    set_in(1'b0, '0, 1'b1, 1'b0);
    qi32.valid_in = 1'b0;       qi32.MajorOpcode_in = '0; qi32.Source1_in = '0;
    qi32.Source2_in = '0;       qi32.OffsetScale_in = '0; qi32.Destination_in = '0;
    qi32.MinorOpcode_in = '0;   qi32.HasAddress_in = 1'b0; qi32.Address_in = '0;
    qi32.OffsetSub_in = 1'b0;   qi32.stall_in = 1'b1;     qi32.flush = 1'b0;
    test_reset();
    test_reset_midstream();
    test_fill();
    test_full_pop();
    test_stream();
    test_flush();
    test_wide_addr();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
